axi_xbar: RTL and testbench

AXI_XBAR -- requirements
Module: axi_xbar

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_addr_dec.sv | 10 +
 rtl/axi_xbar.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_xbar.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the LSU-facing AXI crossbar: CLINT window,
// FSM encodings and packed channel payloads.
package axi_pkg;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } r_rsp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_rsp_t;
endpackage

// File: rtl/axi_addr_dec.sv
// Address window decode: sel=1 routes to the CLINT port, sel=0 to the SoC bus.
module axi_addr_dec import axi_pkg::*; #(
  parameter logic [31:0] BASE = CLINT_BASE,
  parameter logic [31:0] MASK = CLINT_MASK
) (
  input  logic [31:0] addr,
  output logic        sel
);
  assign sel = ((addr & MASK) == BASE);
endmodule

// File: rtl/axi_xbar.sv
// 1x2 AXI4 crossbar: LSU slave port to SoC bus (M0) or CLINT (M1).
// Independent read/write FSMs, one outstanding transaction each.
module axi_xbar #(
  parameter logic [31:0] CLINT_BASE = axi_pkg::CLINT_BASE,
  parameter logic [31:0] CLINT_MASK = axi_pkg::CLINT_MASK
) (
  input  logic        clock,
  input  logic        S_AXI_ARESETN,
  // slave port (core LSU)
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [3:0]  S_AXI_ARID,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [3:0]  S_AXI_RID,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [3:0]  S_AXI_AWID,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  output logic [3:0]  S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  // master port 0 (SoC bus)
  output logic        M0_AXI_ARVALID,
  input  logic        M0_AXI_ARREADY,
  output logic [31:0] M0_AXI_ARADDR,
  output logic [3:0]  M0_AXI_ARID,
  output logic [7:0]  M0_AXI_ARLEN,
  output logic [2:0]  M0_AXI_ARSIZE,
  output logic [1:0]  M0_AXI_ARBURST,
  input  logic        M0_AXI_RVALID,
  output logic        M0_AXI_RREADY,
  input  logic [31:0] M0_AXI_RDATA,
  input  logic [3:0]  M0_AXI_RID,
  input  logic [1:0]  M0_AXI_RRESP,
  input  logic        M0_AXI_RLAST,
  output logic        M0_AXI_AWVALID,
  input  logic        M0_AXI_AWREADY,
  output logic [31:0] M0_AXI_AWADDR,
  output logic [3:0]  M0_AXI_AWID,
  output logic [7:0]  M0_AXI_AWLEN,
  output logic [2:0]  M0_AXI_AWSIZE,
  output logic [1:0]  M0_AXI_AWBURST,
  output logic        M0_AXI_WVALID,
  input  logic        M0_AXI_WREADY,
  output logic [31:0] M0_AXI_WDATA,
  output logic [3:0]  M0_AXI_WSTRB,
  output logic        M0_AXI_WLAST,
  input  logic        M0_AXI_BVALID,
  output logic        M0_AXI_BREADY,
  input  logic [3:0]  M0_AXI_BID,
  input  logic [1:0]  M0_AXI_BRESP,
  // master port 1 (CLINT)
  output logic        M1_AXI_ARVALID,
  input  logic        M1_AXI_ARREADY,
  output logic [31:0] M1_AXI_ARADDR,
  output logic [3:0]  M1_AXI_ARID,
  output logic [7:0]  M1_AXI_ARLEN,
  output logic [2:0]  M1_AXI_ARSIZE,
  output logic [1:0]  M1_AXI_ARBURST,
  input  logic        M1_AXI_RVALID,
  output logic        M1_AXI_RREADY,
  input  logic [31:0] M1_AXI_RDATA,
  input  logic [3:0]  M1_AXI_RID,
  input  logic [1:0]  M1_AXI_RRESP,
  input  logic        M1_AXI_RLAST,
  output logic        M1_AXI_AWVALID,
  input  logic        M1_AXI_AWREADY,
  output logic [31:0] M1_AXI_AWADDR,
  output logic [3:0]  M1_AXI_AWID,
  output logic [7:0]  M1_AXI_AWLEN,
  output logic [2:0]  M1_AXI_AWSIZE,
  output logic [1:0]  M1_AXI_AWBURST,
  output logic        M1_AXI_WVALID,
  input  logic        M1_AXI_WREADY,
  output logic [31:0] M1_AXI_WDATA,
  output logic [3:0]  M1_AXI_WSTRB,
  output logic        M1_AXI_WLAST,
  input  logic        M1_AXI_BVALID,
  output logic        M1_AXI_BREADY,
  input  logic [3:0]  M1_AXI_BID,
  input  logic [1:0]  M1_AXI_BRESP
);
  import axi_pkg::*;

  rd_state_e r_state, r_next;
  wr_state_e w_state, w_next;
  logic      rsel, wsel, aw_done, w_done;
  logic      ar_dec, aw_dec;

  axi_addr_dec #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_ar_dec (.addr(S_AXI_ARADDR), .sel(ar_dec));
  axi_addr_dec #(.BASE(CLINT_BASE), .MASK(CLINT_MASK)) u_aw_dec (.addr(S_AXI_AWADDR), .sel(aw_dec));

  // ---------------- read path ----------------
  logic    r_addr, r_data, sel_arready, sel_rvalid;
  ax_req_t ar_req, m0_ar, m1_ar;
  r_rsp_t  m0_r, m1_r, sel_r;

  assign r_addr      = (r_state == R_ADDR);
  assign r_data      = (r_state == R_DATA);
  assign sel_arready = rsel ? M1_AXI_ARREADY : M0_AXI_ARREADY;
  assign sel_rvalid  = rsel ? M1_AXI_RVALID  : M0_AXI_RVALID;
  assign m0_r        = {M0_AXI_RDATA, M0_AXI_RID, M0_AXI_RRESP, M0_AXI_RLAST};
  assign m1_r        = {M1_AXI_RDATA, M1_AXI_RID, M1_AXI_RRESP, M1_AXI_RLAST};
  assign sel_r       = rsel ? m1_r : m0_r;

  always_ff @(posedge clock or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state <= R_IDLE;
      rsel    <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && S_AXI_ARVALID) rsel <= ar_dec;
    end
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (S_AXI_ARVALID) r_next = R_ADDR;
      R_ADDR:  if (S_AXI_ARVALID && sel_arready) r_next = R_DATA;
      R_DATA:  if (sel_rvalid && S_AXI_RREADY && sel_r.last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // payload is zeroed toward the unselected port so nothing leaks across
  assign ar_req = {S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST};
  assign m0_ar  = (r_addr && !rsel) ? ar_req : '0;
  assign m1_ar  = (r_addr &&  rsel) ? ar_req : '0;
  assign {M0_AXI_ARADDR, M0_AXI_ARID, M0_AXI_ARLEN, M0_AXI_ARSIZE, M0_AXI_ARBURST} = m0_ar;
  assign {M1_AXI_ARADDR, M1_AXI_ARID, M1_AXI_ARLEN, M1_AXI_ARSIZE, M1_AXI_ARBURST} = m1_ar;

  assign M0_AXI_ARVALID = r_addr && !rsel && S_AXI_ARVALID;
  assign M1_AXI_ARVALID = r_addr &&  rsel && S_AXI_ARVALID;
  assign S_AXI_ARREADY  = r_addr && sel_arready;

  assign S_AXI_RVALID   = r_data && sel_rvalid;
  assign {S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST} = r_data ? sel_r : '0;
  assign M0_AXI_RREADY  = r_data && !rsel && S_AXI_RREADY;
  assign M1_AXI_RREADY  = r_data &&  rsel && S_AXI_RREADY;

  // ---------------- write path ----------------
  logic    aw_fwd, w_fwd, aw_hs, w_last_hs;
  logic    sel_awready, sel_wready, sel_bvalid;
  ax_req_t aw_req, m0_aw, m1_aw;
  w_req_t  w_req, m0_w, m1_w;
  b_rsp_t  sel_b;

  assign aw_fwd      = (w_state == W_XFER) && !aw_done;
  assign w_fwd       = (w_state == W_XFER) && !w_done;
  assign sel_awready = wsel ? M1_AXI_AWREADY : M0_AXI_AWREADY;
  assign sel_wready  = wsel ? M1_AXI_WREADY  : M0_AXI_WREADY;
  assign sel_bvalid  = wsel ? M1_AXI_BVALID  : M0_AXI_BVALID;
  assign sel_b       = wsel ? {M1_AXI_BID, M1_AXI_BRESP} : {M0_AXI_BID, M0_AXI_BRESP};
  assign aw_hs       = aw_fwd && S_AXI_AWVALID && sel_awready;
  assign w_last_hs   = w_fwd && S_AXI_WVALID && sel_wready && S_AXI_WLAST;

  always_ff @(posedge clock or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE;
      wsel    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && S_AXI_AWVALID) wsel <= aw_dec;
      // flags only live while in W_XFER; cleared on the way out
      if (w_state != W_XFER || w_next != W_XFER) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs)     aw_done <= 1'b1;
        if (w_last_hs) w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (S_AXI_AWVALID) w_next = W_XFER;
      W_XFER:  if ((aw_done || aw_hs) && (w_done || w_last_hs)) w_next = W_RESP;
      W_RESP:  if (sel_bvalid && S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_req = {S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST};
  assign m0_aw  = (aw_fwd && !wsel) ? aw_req : '0;
  assign m1_aw  = (aw_fwd &&  wsel) ? aw_req : '0;
  assign {M0_AXI_AWADDR, M0_AXI_AWID, M0_AXI_AWLEN, M0_AXI_AWSIZE, M0_AXI_AWBURST} = m0_aw;
  assign {M1_AXI_AWADDR, M1_AXI_AWID, M1_AXI_AWLEN, M1_AXI_AWSIZE, M1_AXI_AWBURST} = m1_aw;
  assign M0_AXI_AWVALID = aw_fwd && !wsel && S_AXI_AWVALID;
  assign M1_AXI_AWVALID = aw_fwd &&  wsel && S_AXI_AWVALID;
  assign S_AXI_AWREADY  = aw_fwd && sel_awready;

  assign w_req = {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST};
  assign m0_w  = (w_fwd && !wsel) ? w_req : '0;
  assign m1_w  = (w_fwd &&  wsel) ? w_req : '0;
  assign {M0_AXI_WDATA, M0_AXI_WSTRB, M0_AXI_WLAST} = m0_w;
  assign {M1_AXI_WDATA, M1_AXI_WSTRB, M1_AXI_WLAST} = m1_w;
  assign M0_AXI_WVALID = w_fwd && !wsel && S_AXI_WVALID;
  assign M1_AXI_WVALID = w_fwd &&  wsel && S_AXI_WVALID;
  assign S_AXI_WREADY  = w_fwd && sel_wready;

  assign S_AXI_BVALID  = (w_state == W_RESP) && sel_bvalid;
  assign {S_AXI_BID, S_AXI_BRESP} = (w_state == W_RESP) ? sel_b : '0;
  assign M0_AXI_BREADY = (w_state == W_RESP) && !wsel && S_AXI_BREADY;
  assign M1_AXI_BREADY = (w_state == W_RESP) &&  wsel && S_AXI_BREADY;
endmodule

// File: tb/tb_axi_xbar.sv
// Directed bench for axi_xbar: both master ports are driven cycle by cycle.
module tb_axi_xbar;
  import axi_pkg::*;

  logic clock = 1'b0;
  logic S_AXI_ARESETN;
  always #5 clock = ~clock;

  logic        S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY, S_AXI_RLAST;
  logic [31:0] S_AXI_ARADDR, S_AXI_RDATA, S_AXI_AWADDR, S_AXI_WDATA;
  logic [3:0]  S_AXI_ARID, S_AXI_RID, S_AXI_AWID, S_AXI_WSTRB, S_AXI_BID;
  logic [7:0]  S_AXI_ARLEN, S_AXI_AWLEN;
  logic [2:0]  S_AXI_ARSIZE, S_AXI_AWSIZE;
  logic [1:0]  S_AXI_ARBURST, S_AXI_AWBURST, S_AXI_RRESP, S_AXI_BRESP;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_WLAST;
  logic        S_AXI_BVALID, S_AXI_BREADY;

  logic        M0_AXI_ARVALID, M0_AXI_ARREADY, M0_AXI_RVALID, M0_AXI_RREADY, M0_AXI_RLAST;
  logic [31:0] M0_AXI_ARADDR, M0_AXI_RDATA, M0_AXI_AWADDR, M0_AXI_WDATA;
  logic [3:0]  M0_AXI_ARID, M0_AXI_RID, M0_AXI_AWID, M0_AXI_WSTRB, M0_AXI_BID;
  logic [7:0]  M0_AXI_ARLEN, M0_AXI_AWLEN;
  logic [2:0]  M0_AXI_ARSIZE, M0_AXI_AWSIZE;
  logic [1:0]  M0_AXI_ARBURST, M0_AXI_AWBURST, M0_AXI_RRESP, M0_AXI_BRESP;
  logic        M0_AXI_AWVALID, M0_AXI_AWREADY, M0_AXI_WVALID, M0_AXI_WREADY, M0_AXI_WLAST;
  logic        M0_AXI_BVALID, M0_AXI_BREADY;

  logic        M1_AXI_ARVALID, M1_AXI_ARREADY, M1_AXI_RVALID, M1_AXI_RREADY, M1_AXI_RLAST;
  logic [31:0] M1_AXI_ARADDR, M1_AXI_RDATA, M1_AXI_AWADDR, M1_AXI_WDATA;
  logic [3:0]  M1_AXI_ARID, M1_AXI_RID, M1_AXI_AWID, M1_AXI_WSTRB, M1_AXI_BID;
  logic [7:0]  M1_AXI_ARLEN, M1_AXI_AWLEN;
  logic [2:0]  M1_AXI_ARSIZE, M1_AXI_AWSIZE;
  logic [1:0]  M1_AXI_ARBURST, M1_AXI_AWBURST, M1_AXI_RRESP, M1_AXI_BRESP;
  logic        M1_AXI_AWVALID, M1_AXI_AWREADY, M1_AXI_WVALID, M1_AXI_WREADY, M1_AXI_WLAST;
  logic        M1_AXI_BVALID, M1_AXI_BREADY;

  int checks = 0, failures = 0;
  logic [31:0] clint_word;
  logic [14:0] hs_out;
  assign hs_out = {S_AXI_ARREADY, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                   M0_AXI_ARVALID, M0_AXI_RREADY, M0_AXI_AWVALID, M0_AXI_WVALID, M0_AXI_BREADY,
                   M1_AXI_ARVALID, M1_AXI_RREADY, M1_AXI_AWVALID, M1_AXI_WVALID, M1_AXI_BREADY};

  axi_xbar dut (
    .clock(clock), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWADDR(S_AXI_AWADDR),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_WDATA(S_AXI_WDATA),
    .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
    .M0_AXI_ARVALID(M0_AXI_ARVALID), .M0_AXI_ARREADY(M0_AXI_ARREADY), .M0_AXI_ARADDR(M0_AXI_ARADDR),
    .M0_AXI_ARID(M0_AXI_ARID), .M0_AXI_ARLEN(M0_AXI_ARLEN), .M0_AXI_ARSIZE(M0_AXI_ARSIZE), .M0_AXI_ARBURST(M0_AXI_ARBURST),
    .M0_AXI_RVALID(M0_AXI_RVALID), .M0_AXI_RREADY(M0_AXI_RREADY), .M0_AXI_RDATA(M0_AXI_RDATA),
    .M0_AXI_RID(M0_AXI_RID), .M0_AXI_RRESP(M0_AXI_RRESP), .M0_AXI_RLAST(M0_AXI_RLAST),
    .M0_AXI_AWVALID(M0_AXI_AWVALID), .M0_AXI_AWREADY(M0_AXI_AWREADY), .M0_AXI_AWADDR(M0_AXI_AWADDR),
    .M0_AXI_AWID(M0_AXI_AWID), .M0_AXI_AWLEN(M0_AXI_AWLEN), .M0_AXI_AWSIZE(M0_AXI_AWSIZE), .M0_AXI_AWBURST(M0_AXI_AWBURST),
    .M0_AXI_WVALID(M0_AXI_WVALID), .M0_AXI_WREADY(M0_AXI_WREADY), .M0_AXI_WDATA(M0_AXI_WDATA),
    .M0_AXI_WSTRB(M0_AXI_WSTRB), .M0_AXI_WLAST(M0_AXI_WLAST),
    .M0_AXI_BVALID(M0_AXI_BVALID), .M0_AXI_BREADY(M0_AXI_BREADY), .M0_AXI_BID(M0_AXI_BID), .M0_AXI_BRESP(M0_AXI_BRESP),
    .M1_AXI_ARVALID(M1_AXI_ARVALID), .M1_AXI_ARREADY(M1_AXI_ARREADY), .M1_AXI_ARADDR(M1_AXI_ARADDR),
    .M1_AXI_ARID(M1_AXI_ARID), .M1_AXI_ARLEN(M1_AXI_ARLEN), .M1_AXI_ARSIZE(M1_AXI_ARSIZE), .M1_AXI_ARBURST(M1_AXI_ARBURST),
    .M1_AXI_RVALID(M1_AXI_RVALID), .M1_AXI_RREADY(M1_AXI_RREADY), .M1_AXI_RDATA(M1_AXI_RDATA),
    .M1_AXI_RID(M1_AXI_RID), .M1_AXI_RRESP(M1_AXI_RRESP), .M1_AXI_RLAST(M1_AXI_RLAST),
    .M1_AXI_AWVALID(M1_AXI_AWVALID), .M1_AXI_AWREADY(M1_AXI_AWREADY), .M1_AXI_AWADDR(M1_AXI_AWADDR),
    .M1_AXI_AWID(M1_AXI_AWID), .M1_AXI_AWLEN(M1_AXI_AWLEN), .M1_AXI_AWSIZE(M1_AXI_AWSIZE), .M1_AXI_AWBURST(M1_AXI_AWBURST),
    .M1_AXI_WVALID(M1_AXI_WVALID), .M1_AXI_WREADY(M1_AXI_WREADY), .M1_AXI_WDATA(M1_AXI_WDATA),
    .M1_AXI_WSTRB(M1_AXI_WSTRB), .M1_AXI_WLAST(M1_AXI_WLAST),
    .M1_AXI_BVALID(M1_AXI_BVALID), .M1_AXI_BREADY(M1_AXI_BREADY), .M1_AXI_BID(M1_AXI_BID), .M1_AXI_BRESP(M1_AXI_BRESP)
  );

  task automatic tick; @(negedge clock); endtask

  task automatic clear_inputs;
    S_AXI_ARVALID = 0; S_AXI_ARADDR = 0; S_AXI_ARID = 0; S_AXI_ARLEN = 0; S_AXI_ARSIZE = 3'd2; S_AXI_ARBURST = 2'd1;
    S_AXI_RREADY = 0; S_AXI_AWVALID = 0; S_AXI_AWADDR = 0; S_AXI_AWID = 0; S_AXI_AWLEN = 0;
    S_AXI_AWSIZE = 3'd2; S_AXI_AWBURST = 2'd1; S_AXI_WVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
    S_AXI_WLAST = 0; S_AXI_BREADY = 0;
    M0_AXI_ARREADY = 0; M0_AXI_RVALID = 0; M0_AXI_RDATA = 0; M0_AXI_RID = 0; M0_AXI_RRESP = 0; M0_AXI_RLAST = 0;
    M0_AXI_AWREADY = 0; M0_AXI_WREADY = 0; M0_AXI_BVALID = 0; M0_AXI_BID = 0; M0_AXI_BRESP = 0;
    M1_AXI_ARREADY = 0; M1_AXI_RVALID = 0; M1_AXI_RDATA = 0; M1_AXI_RID = 0; M1_AXI_RRESP = 0; M1_AXI_RLAST = 0;
    M1_AXI_AWREADY = 0; M1_AXI_WREADY = 0; M1_AXI_BVALID = 0; M1_AXI_BID = 0; M1_AXI_BRESP = 0;
  endtask

  task automatic test_reset;
    S_AXI_ARESETN = 0; clear_inputs();
    S_AXI_ARVALID = 1; S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_RREADY = 1; S_AXI_BREADY = 1;
    M0_AXI_ARREADY = 1; M0_AXI_RVALID = 1; M0_AXI_AWREADY = 1; M0_AXI_WREADY = 1; M0_AXI_BVALID = 1;
    M1_AXI_ARREADY = 1; M1_AXI_RVALID = 1; M1_AXI_AWREADY = 1; M1_AXI_WREADY = 1; M1_AXI_BVALID = 1;
    repeat (3) tick(); #1;
    checks++; if (hs_out !== 15'h0) begin failures++; $display("FAIL reset_hs got=%h exp=0", hs_out); end
    checks++; if (dut.r_state !== R_IDLE || dut.w_state !== W_IDLE) begin failures++;
      $display("FAIL reset_state got=%0d/%0d exp=0/0", dut.r_state, dut.w_state); end
    checks++; if ({dut.rsel, dut.wsel, dut.aw_done, dut.w_done} !== 4'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=0000", {dut.rsel, dut.wsel, dut.aw_done, dut.w_done}); end
    tick(); clear_inputs(); S_AXI_ARESETN = 1;
  endtask

  task automatic test_read_clint;
    tick(); S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h0200_0000; S_AXI_ARID = 4'h3; M1_AXI_ARREADY = 1; #1;
    checks++; if (S_AXI_ARREADY !== 1'b0) begin failures++; $display("FAIL rd_idle_arready got=%b exp=0", S_AXI_ARREADY); end
    tick(); #1;
    checks++; if ({M1_AXI_ARVALID, M0_AXI_ARVALID, S_AXI_ARREADY} !== 3'b101) begin failures++;
      $display("FAIL rd_clint_route got=%b exp=101", {M1_AXI_ARVALID, M0_AXI_ARVALID, S_AXI_ARREADY}); end
    checks++; if (M1_AXI_ARADDR !== 32'h0200_0000 || M1_AXI_ARID !== 4'h3) begin failures++;
      $display("FAIL rd_clint_addr got=%h/%h exp=02000000/3", M1_AXI_ARADDR, M1_AXI_ARID); end
    tick(); S_AXI_ARVALID = 0; M1_AXI_ARREADY = 0; S_AXI_RREADY = 1;
    M1_AXI_RVALID = 1; M1_AXI_RDATA = 32'h0000_1F40; M1_AXI_RID = 4'h3; M1_AXI_RLAST = 1; #1;
    checks++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0000_1F40 || S_AXI_RLAST !== 1'b1) begin failures++;
      $display("FAIL rd_clint_data got=%b/%h exp=1/00001f40", S_AXI_RVALID, S_AXI_RDATA); end
    checks++; if ({M1_AXI_RREADY, M0_AXI_RREADY} !== 2'b10) begin failures++;
      $display("FAIL rd_clint_rready got=%b exp=10", {M1_AXI_RREADY, M0_AXI_RREADY}); end
    tick(); clear_inputs(); #1;
    checks++; if (dut.r_state !== R_IDLE) begin failures++; $display("FAIL rd_clint_idle got=%0d exp=0", dut.r_state); end
  endtask

  task automatic test_write_clint;
    tick(); S_AXI_AWVALID = 1; S_AXI_AWADDR = 32'h0200_0004; S_AXI_AWID = 4'h6;
    S_AXI_WVALID = 1; S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1;
    M1_AXI_AWREADY = 1; M1_AXI_WREADY = 1; #1;
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin failures++;
      $display("FAIL wr_idle_ready got=%b exp=00", {S_AXI_AWREADY, S_AXI_WREADY}); end
    tick(); #1;
    checks++; if ({M1_AXI_AWVALID, M1_AXI_WVALID, M0_AXI_AWVALID, M0_AXI_WVALID} !== 4'b1100) begin failures++;
      $display("FAIL wr_clint_route got=%b exp=1100", {M1_AXI_AWVALID, M1_AXI_WVALID, M0_AXI_AWVALID, M0_AXI_WVALID}); end
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin failures++;
      $display("FAIL wr_clint_ready got=%b exp=11", {S_AXI_AWREADY, S_AXI_WREADY}); end
    clint_word = (M1_AXI_WSTRB == 4'hF) ? M1_AXI_WDATA : 32'h0;
    tick(); clear_inputs(); M1_AXI_BVALID = 1; M1_AXI_BID = 4'h6; M1_AXI_BRESP = 2'b00; S_AXI_BREADY = 1; #1;
    checks++; if (S_AXI_BVALID !== 1'b1 || S_AXI_BID !== 4'h6 || dut.w_state !== W_RESP) begin failures++;
      $display("FAIL wr_clint_b got=%b/%h/%0d exp=1/6/2", S_AXI_BVALID, S_AXI_BID, dut.w_state); end
    tick(); clear_inputs();
    // read the CLINT word back through the crossbar
    S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h0200_0004; M1_AXI_ARREADY = 1;
    tick(); #1;
    checks++; if (M1_AXI_ARVALID !== 1'b1 || M1_AXI_ARADDR !== 32'h0200_0004) begin failures++;
      $display("FAIL rb_addr got=%b/%h exp=1/02000004", M1_AXI_ARVALID, M1_AXI_ARADDR); end
    tick(); clear_inputs(); M1_AXI_RVALID = 1; M1_AXI_RDATA = clint_word; M1_AXI_RLAST = 1; S_AXI_RREADY = 1; #1;
    checks++; if (S_AXI_RDATA !== 32'h1234_5678) begin failures++; $display("FAIL rb_data got=%h exp=12345678", S_AXI_RDATA); end
    tick(); clear_inputs();
  endtask

  task automatic test_burst_m0;
    tick(); S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h8000_0000; S_AXI_ARLEN = 8'd3; M0_AXI_ARREADY = 1;
    tick(); #1;
    checks++; if ({M0_AXI_ARVALID, M1_AXI_ARVALID} !== 2'b10 || M0_AXI_ARLEN !== 8'd3) begin failures++;
      $display("FAIL burst_route got=%b/%0d exp=10/3", {M0_AXI_ARVALID, M1_AXI_ARVALID}, M0_AXI_ARLEN); end
    // keep a second request pending to show it is not accepted mid-burst
    tick(); M0_AXI_ARREADY = 0; M1_AXI_ARREADY = 1; S_AXI_ARADDR = 32'h0200_0000; S_AXI_ARLEN = 0; S_AXI_RREADY = 1;
    for (int k = 0; k < 4; k++) begin
      M0_AXI_RVALID = 1; M0_AXI_RDATA = 32'hA000_0000 + k; M0_AXI_RLAST = (k == 3); #1;
      checks++; if (S_AXI_RDATA !== 32'hA000_0000 + k || S_AXI_RVALID !== 1'b1 || S_AXI_RLAST !== (k == 3)) begin failures++;
        $display("FAIL burst_beat%0d got=%h/%b exp=%h/%b", k, S_AXI_RDATA, S_AXI_RLAST, 32'hA000_0000 + k, k == 3); end
      checks++; if (S_AXI_ARREADY !== 1'b0 || M1_AXI_ARVALID !== 1'b0) begin failures++;
        $display("FAIL burst_arready%0d got=%b/%b exp=0/0", k, S_AXI_ARREADY, M1_AXI_ARVALID); end
      tick();
    end
    S_AXI_ARVALID = 0; M0_AXI_RVALID = 0; M0_AXI_RLAST = 0; #1;
    checks++; if (dut.r_state !== R_IDLE) begin failures++; $display("FAIL burst_idle got=%0d exp=0", dut.r_state); end
    clear_inputs();
  endtask

  task automatic test_write_w_first;
    tick(); S_AXI_WVALID = 1; S_AXI_WDATA = 32'hCAFE_0001; S_AXI_WSTRB = 4'hF; S_AXI_WLAST = 1; M0_AXI_WREADY = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({S_AXI_WREADY, M0_AXI_WVALID, M1_AXI_WVALID} !== 3'b000) begin failures++;
        $display("FAIL wfirst_hold%0d got=%b exp=000", k, {S_AXI_WREADY, M0_AXI_WVALID, M1_AXI_WVALID}); end
      tick();
    end
    S_AXI_AWVALID = 1; S_AXI_AWADDR = 32'h0201_0000;
    tick(); #1;
    checks++; if ({M0_AXI_WVALID, M0_AXI_AWVALID, M1_AXI_WVALID, M1_AXI_AWVALID, S_AXI_WREADY} !== 5'b11001) begin failures++;
      $display("FAIL wfirst_route got=%b exp=11001", {M0_AXI_WVALID, M0_AXI_AWVALID, M1_AXI_WVALID, M1_AXI_AWVALID, S_AXI_WREADY}); end
    tick(); S_AXI_WVALID = 0; M0_AXI_WREADY = 0; M0_AXI_AWREADY = 1; #1;
    checks++; if (dut.w_state !== W_XFER || M0_AXI_WVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin failures++;
      $display("FAIL wfirst_wait_aw got=%0d/%b/%b exp=1/0/1", dut.w_state, M0_AXI_WVALID, S_AXI_AWREADY); end
    tick(); clear_inputs(); M0_AXI_BVALID = 1; M0_AXI_BRESP = 2'b10; M0_AXI_BID = 4'h9; S_AXI_BREADY = 1; #1;
    checks++; if (dut.w_state !== W_RESP || S_AXI_BRESP !== 2'b10 || S_AXI_BID !== 4'h9 || M0_AXI_BREADY !== 1'b1) begin failures++;
      $display("FAIL wfirst_b got=%0d/%b/%h exp=2/10/9", dut.w_state, S_AXI_BRESP, S_AXI_BID); end
    tick(); clear_inputs(); #1;
    checks++; if (dut.w_state !== W_IDLE) begin failures++; $display("FAIL wfirst_idle got=%0d exp=0", dut.w_state); end
  endtask

  task automatic test_boundary;
    logic [31:0] addrs [2];
    addrs[0] = 32'h0200_FFFF; addrs[1] = 32'h0201_0000;
    for (int i = 0; i < 2; i++) begin
      tick(); S_AXI_ARVALID = 1; S_AXI_ARADDR = addrs[i]; M0_AXI_ARREADY = 1; M1_AXI_ARREADY = 1;
      tick(); #1;
      checks++; if ({M1_AXI_ARVALID, M0_AXI_ARVALID} !== ((i == 0) ? 2'b10 : 2'b01)) begin failures++;
        $display("FAIL bound_route%0d got=%b", i, {M1_AXI_ARVALID, M0_AXI_ARVALID}); end
      tick(); clear_inputs(); S_AXI_RREADY = 1;
      M0_AXI_RVALID = 1; M0_AXI_RDATA = 32'hD0D0_0000; M0_AXI_RLAST = 1;
      M1_AXI_RVALID = 1; M1_AXI_RDATA = 32'hC1C1_0000; M1_AXI_RLAST = 1; #1;
      checks++; if (S_AXI_RDATA !== ((i == 0) ? 32'hC1C1_0000 : 32'hD0D0_0000)) begin failures++;
        $display("FAIL bound_data%0d got=%h", i, S_AXI_RDATA); end
      tick(); clear_inputs();
    end
  endtask

  task automatic test_concurrent;
    tick(); S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h0200_0000;
    S_AXI_AWVALID = 1; S_AXI_AWADDR = 32'h8000_0010; S_AXI_AWID = 4'h5;
    S_AXI_WVALID = 1; S_AXI_WDATA = 32'h5555_AAAA; S_AXI_WSTRB = 4'h3; S_AXI_WLAST = 1;
    tick(); M1_AXI_ARREADY = 1; M0_AXI_AWREADY = 1; M0_AXI_WREADY = 1; #1;
    checks++; if ({M1_AXI_ARVALID, M0_AXI_ARVALID, M0_AXI_AWVALID, M1_AXI_AWVALID, M0_AXI_WVALID, M1_AXI_WVALID} !== 6'b101010) begin failures++;
      $display("FAIL conc_route got=%b exp=101010", {M1_AXI_ARVALID, M0_AXI_ARVALID, M0_AXI_AWVALID, M1_AXI_AWVALID, M0_AXI_WVALID, M1_AXI_WVALID}); end
    checks++; if (M0_AXI_WDATA !== 32'h5555_AAAA || M0_AXI_WSTRB !== 4'h3 || M1_AXI_WDATA !== 32'h0) begin failures++;
      $display("FAIL conc_wdata got=%h/%h exp=5555aaaa/0", M0_AXI_WDATA, M1_AXI_WDATA); end
    tick(); clear_inputs(); S_AXI_RREADY = 1; S_AXI_BREADY = 1;
    M1_AXI_RVALID = 1; M1_AXI_RDATA = 32'h1111_2222; M1_AXI_RLAST = 1;
    M0_AXI_BVALID = 1; M0_AXI_BID = 4'h5; M0_AXI_BRESP = 2'b01; #1;
    checks++; if (S_AXI_RDATA !== 32'h1111_2222 || S_AXI_BID !== 4'h5 || S_AXI_BRESP !== 2'b01) begin failures++;
      $display("FAIL conc_resp got=%h/%h/%b exp=11112222/5/01", S_AXI_RDATA, S_AXI_BID, S_AXI_BRESP); end
    checks++; if ({M1_AXI_RREADY, M0_AXI_RREADY, M0_AXI_BREADY, M1_AXI_BREADY} !== 4'b1010) begin failures++;
      $display("FAIL conc_ready got=%b exp=1010", {M1_AXI_RREADY, M0_AXI_RREADY, M0_AXI_BREADY, M1_AXI_BREADY}); end
    tick(); clear_inputs(); #1;
    checks++; if (dut.r_state !== R_IDLE || dut.w_state !== W_IDLE) begin failures++;
      $display("FAIL conc_idle got=%0d/%0d exp=0/0", dut.r_state, dut.w_state); end
  endtask

  task automatic test_reset_mid;
    tick(); S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h8000_0000; S_AXI_ARLEN = 8'd1; M0_AXI_ARREADY = 1;
    tick();
    tick(); S_AXI_ARVALID = 0; M0_AXI_ARREADY = 0; S_AXI_RREADY = 1;
    M0_AXI_RVALID = 1; M0_AXI_RDATA = 32'hBEEF_0000; M0_AXI_RLAST = 0;
    tick(); M0_AXI_RLAST = 1; #1;
    checks++; if (dut.r_state !== R_DATA || S_AXI_RVALID !== 1'b1) begin failures++;
      $display("FAIL rstmid_pre got=%0d/%b exp=2/1", dut.r_state, S_AXI_RVALID); end
    #1 S_AXI_ARESETN = 0; #1;
    checks++; if (hs_out !== 15'h0 || dut.r_state !== R_IDLE) begin failures++;
      $display("FAIL rstmid_async got=%h/%0d exp=0/0", hs_out, dut.r_state); end
    tick(); S_AXI_ARESETN = 1; #1;
    checks++; if (S_AXI_RVALID !== 1'b0 || M0_AXI_RREADY !== 1'b0) begin failures++;
      $display("FAIL rstmid_stale got=%b/%b exp=0/0", S_AXI_RVALID, M0_AXI_RREADY); end
    clear_inputs();
    tick(); S_AXI_ARVALID = 1; S_AXI_ARADDR = 32'h0200_0000; M1_AXI_ARREADY = 1;
    tick(); #1;
    checks++; if (M1_AXI_ARVALID !== 1'b1 || S_AXI_ARREADY !== 1'b1) begin failures++;
      $display("FAIL rstmid_ar got=%b/%b exp=1/1", M1_AXI_ARVALID, S_AXI_ARREADY); end
    tick(); clear_inputs(); S_AXI_RREADY = 1; M1_AXI_RVALID = 1; M1_AXI_RDATA = 32'h0000_2000; M1_AXI_RLAST = 1; #1;
    checks++; if (S_AXI_RDATA !== 32'h0000_2000 || S_AXI_RVALID !== 1'b1) begin failures++;
      $display("FAIL rstmid_data got=%h/%b exp=00002000/1", S_AXI_RDATA, S_AXI_RVALID); end
    tick(); clear_inputs(); #1;
    checks++; if (dut.r_state !== R_IDLE) begin failures++; $display("FAIL rstmid_idle got=%0d exp=0", dut.r_state); end
  endtask

  initial begin
    clint_word = 32'h0;
    test_reset();
    test_read_clint();
    test_write_clint();
    test_burst_m0();
    test_write_w_first();
    test_boundary();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
